// File: rtl/fft_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fft_pkg
//  Description : Shared types and constants for the FFT stage sequencer
//                slice: sequencer state encoding, default transform size
//                and complex-sample width helper.
//  Revision    : 1.0
// ============================================================================
package fft_pkg;

   // Default log2 of the transform length
   localparam int LOG2N_DEFAULT = 10;

   // Sequencer states
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } seq_state_t;

   // A complex sample is packed as {re, im}
   function automatic int cplx_width(input int data_width);
      return 2 * data_width;
   endfunction

endpackage
`default_nettype wire

// File: rtl/fft_addr_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : fft_addr_fifo
//  Description : Small synchronous first-word-fall-through FIFO holding the
//                {addr_a, addr_b} pairs of butterflies still in flight.
//  Revision    : 1.0
// ============================================================================
module fft_addr_fifo
   import fft_pkg::*;
#(
   parameter int WIDTH = 6,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_data,
   output logic             o_full,
   output logic             o_empty
);
   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             do_push, do_pop;

   // Status flags and pointer advance; a push into a full FIFO is only
   // accepted when a pop frees a slot in the same cycle
   always_comb begin
      o_empty  = (wr_ptr_q == rd_ptr_q);
      o_full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
      do_pop   = i_pop && !o_empty;
      do_push  = i_push && (!o_full || do_pop);
      wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
      o_data   = mem_q[rd_ptr_q[AW-1:0]];
   end

   // Pointer registers; reset flushes the FIFO
   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage array, contents are don't-care until written
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q[AW-1:0]] <= i_data;
      end
   end

endmodule
`default_nettype wire

// File: rtl/fft_stage_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : fft_stage_sequencer
//  Description : Control for an in-place radix-2 DIT FFT. Issues one
//                butterfly read per cycle, tracks in-flight butterflies in an
//                address FIFO, writes results back and drains between stages
//                so no stage reads data the previous stage has not written.
//  Revision    : 1.0
// ============================================================================
module fft_stage_sequencer
   import fft_pkg::*;
#(
   parameter int LOG2N      = LOG2N_DEFAULT,
   parameter int DATA_WIDTH = 24,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    i_start,
   output logic                    o_busy,
   output logic                    o_done,
   output logic                    o_err,
   output logic                    o_rd_en,
   output logic [LOG2N-1:0]        o_rd_addr_a,
   output logic [LOG2N-1:0]        o_rd_addr_b,
   output logic [LOG2N-2:0]        o_tw_addr,
   output logic                    o_bfly_start,
   input  logic                    i_bfly_valid,
   input  logic [2*DATA_WIDTH-1:0] i_bfly_data_a,
   input  logic [2*DATA_WIDTH-1:0] i_bfly_data_b,
   output logic                    o_wr_en,
   output logic [LOG2N-1:0]        o_wr_addr_a,
   output logic [LOG2N-1:0]        o_wr_addr_b,
   output logic [2*DATA_WIDTH-1:0] o_wr_data_a,
   output logic [2*DATA_WIDTH-1:0] o_wr_data_b
);
   localparam int CW = cplx_width(DATA_WIDTH);
   localparam int KW = LOG2N - 1;
   localparam int SW = (LOG2N > 1) ? $clog2(LOG2N) : 1;
   localparam int OW = $clog2(FIFO_DEPTH) + 1;
   localparam logic [KW-1:0] K_LAST = '1;
   localparam logic [SW-1:0] S_LAST = SW'(LOG2N - 1);

   seq_state_t       state_q, state_d;
   logic [KW-1:0]    k_q, k_d;
   logic [SW-1:0]    stage_q, stage_d;
   logic [OW-1:0]    outst_q, outst_d;
   logic             busy_q, busy_d, done_q, done_d, err_q, err_d;
   logic             rd_en_q, rd_en_d, bfly_start_q, bfly_start_d;
   logic [LOG2N-1:0] rd_addr_a_q, rd_addr_a_d, rd_addr_b_q, rd_addr_b_d;
   logic [KW-1:0]    tw_q, tw_d;
   logic             wr_en_q, wr_en_d;
   logic [LOG2N-1:0] wr_addr_a_q, wr_addr_a_d, wr_addr_b_q, wr_addr_b_d;
   logic [CW-1:0]    wr_data_a_q, wr_data_a_d, wr_data_b_q, wr_data_b_d;

   logic [KW-1:0]      pos_mask, pos;
   logic [LOG2N-1:0]   addr_a, addr_b;
   logic               fifo_full, fifo_empty, push, pop;
   logic [2*LOG2N-1:0] fifo_head;

   // Butterfly k of the current stage: the low `stage` bits of k select the
   // position in the group, the rest pick the group (spaced 2*half apart)
   always_comb begin
      pos_mask = KW'((32'd1 << stage_q) - 32'd1);
      pos      = k_q & pos_mask;
      addr_a   = {k_q & ~pos_mask, 1'b0} | {1'b0, pos};
      addr_b   = addr_a | LOG2N'(32'd1 << stage_q);
   end

   // The FIFO entry is pushed on the cycle the read is presented
   assign push = rd_en_q;
   assign pop  = i_bfly_valid && !fifo_empty;

   fft_addr_fifo #(
      .WIDTH (2 * LOG2N),
      .DEPTH (FIFO_DEPTH)
   ) u_addr_fifo (
      .clk     (clk),
      .reset   (reset),
      .i_push  (push),
      .i_data  ({rd_addr_a_q, rd_addr_b_q}),
      .i_pop   (i_bfly_valid),
      .o_data  (fifo_head),
      .o_full  (fifo_full),
      .o_empty (fifo_empty)
   );

   // Next-state logic: issue, drain, completion and write-back capture
   always_comb begin
      state_d      = state_q;
      k_d          = k_q;
      stage_d      = stage_q;
      busy_d       = busy_q;
      done_d       = 1'b0;
      rd_en_d      = 1'b0;
      rd_addr_a_d  = rd_addr_a_q;
      rd_addr_b_d  = rd_addr_b_q;
      tw_d         = tw_q;
      bfly_start_d = rd_en_q;
      wr_en_d      = pop;
      wr_addr_a_d  = pop ? fifo_head[2*LOG2N-1:LOG2N] : wr_addr_a_q;
      wr_addr_b_d  = pop ? fifo_head[LOG2N-1:0]       : wr_addr_b_q;
      wr_data_a_d  = pop ? i_bfly_data_a              : wr_data_a_q;
      wr_data_b_d  = pop ? i_bfly_data_b              : wr_data_b_q;
      err_d        = err_q | (i_bfly_valid && fifo_empty) | (push && fifo_full);

      case ({push, pop})
         2'b10:   outst_d = outst_q + 1'b1;
         2'b01:   outst_d = outst_q - 1'b1;
         default: outst_d = outst_q;
      endcase

      case (state_q)
         ST_IDLE: begin
            if (i_start) begin
               state_d = ST_RUN;
               k_d     = '0;
               stage_d = '0;
               busy_d  = 1'b1;
            end
         end
         ST_RUN: begin
            rd_en_d     = 1'b1;
            rd_addr_a_d = addr_a;
            rd_addr_b_d = addr_b;
            tw_d        = pos << (S_LAST - stage_q);
            if (k_q == K_LAST) begin
               state_d = ST_DRAIN;
               k_d     = '0;
            end else begin
               k_d = k_q + 1'b1;
            end
         end
         ST_DRAIN: begin
            // The last read of the stage is still on the bus in the first
            // drain cycle and not yet counted as outstanding
            if ((outst_q == '0) && !rd_en_q) begin
               if (stage_q == S_LAST) begin
                  state_d = ST_DONE;
                  done_d  = 1'b1;
               end else begin
                  state_d = ST_RUN;
                  stage_d = stage_q + 1'b1;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State and registered outputs
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q      <= ST_IDLE;
         k_q          <= '0;
         stage_q      <= '0;
         outst_q      <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
         rd_en_q      <= 1'b0;
         rd_addr_a_q  <= '0;
         rd_addr_b_q  <= '0;
         tw_q         <= '0;
         bfly_start_q <= 1'b0;
         wr_en_q      <= 1'b0;
         wr_addr_a_q  <= '0;
         wr_addr_b_q  <= '0;
         wr_data_a_q  <= '0;
         wr_data_b_q  <= '0;
      end else begin
         state_q      <= state_d;
         k_q          <= k_d;
         stage_q      <= stage_d;
         outst_q      <= outst_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         err_q        <= err_d;
         rd_en_q      <= rd_en_d;
         rd_addr_a_q  <= rd_addr_a_d;
         rd_addr_b_q  <= rd_addr_b_d;
         tw_q         <= tw_d;
         bfly_start_q <= bfly_start_d;
         wr_en_q      <= wr_en_d;
         wr_addr_a_q  <= wr_addr_a_d;
         wr_addr_b_q  <= wr_addr_b_d;
         wr_data_a_q  <= wr_data_a_d;
         wr_data_b_q  <= wr_data_b_d;
      end
   end

   assign o_busy       = busy_q;
   assign o_done       = done_q;
   assign o_err        = err_q;
   assign o_rd_en      = rd_en_q;
   assign o_rd_addr_a  = rd_addr_a_q;
   assign o_rd_addr_b  = rd_addr_b_q;
   assign o_tw_addr    = tw_q;
   assign o_bfly_start = bfly_start_q;
   assign o_wr_en      = wr_en_q;
   assign o_wr_addr_a  = wr_addr_a_q;
   assign o_wr_addr_b  = wr_addr_b_q;
   assign o_wr_data_a  = wr_data_a_q;
   assign o_wr_data_b  = wr_data_b_q;

endmodule
`default_nettype wire

// File: tb/tb_fft_stage_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fft_stage_sequencer
//  Description : Self-checking bench for fft_stage_sequencer with LOG2N=3,
//                a sample RAM model and a variable-latency butterfly model.
//  Revision    : 1.0
// ============================================================================
module tb_fft_stage_sequencer;
   localparam int LOG2N = 3;
   localparam int N     = 8;
   localparam int DW    = 24;
   localparam int CW    = 2 * DW;

   logic clk = 1'b0, reset = 1'b0, i_start = 1'b0;
   logic o_busy, o_done, o_err, o_rd_en, o_bfly_start, o_wr_en;
   logic [LOG2N-1:0] o_rd_addr_a, o_rd_addr_b, o_wr_addr_a, o_wr_addr_b;
   logic [LOG2N-2:0] o_tw_addr;
   logic i_bfly_valid;
   logic [CW-1:0] i_bfly_data_a, i_bfly_data_b, o_wr_data_a, o_wr_data_b;

   fft_stage_sequencer #(.LOG2N(LOG2N), .DATA_WIDTH(DW), .FIFO_DEPTH(8)) dut (
      .clk(clk), .reset(reset), .i_start(i_start),
      .o_busy(o_busy), .o_done(o_done), .o_err(o_err),
      .o_rd_en(o_rd_en), .o_rd_addr_a(o_rd_addr_a), .o_rd_addr_b(o_rd_addr_b),
      .o_tw_addr(o_tw_addr), .o_bfly_start(o_bfly_start),
      .i_bfly_valid(i_bfly_valid), .i_bfly_data_a(i_bfly_data_a),
      .i_bfly_data_b(i_bfly_data_b), .o_wr_en(o_wr_en),
      .o_wr_addr_a(o_wr_addr_a), .o_wr_addr_b(o_wr_addr_b),
      .o_wr_data_a(o_wr_data_a), .o_wr_data_b(o_wr_data_b)
   );

   always #5 clk = ~clk;

   // Ideal butterfly, Q14 twiddles W8^k = cos - j*sin
   function automatic logic [95:0] bfly(input logic [47:0] a, input logic [47:0] b, input int tw);
      longint ar, ai, br, bi, wr, wi, pr, pi;
      ar = longint'($signed(a[47:24])); ai = longint'($signed(a[23:0]));
      br = longint'($signed(b[47:24])); bi = longint'($signed(b[23:0]));
      case (tw)
         1:       begin wr = 11585;  wi = -11585; end
         2:       begin wr = 0;      wi = -16384; end
         3:       begin wr = -11585; wi = -11585; end
         default: begin wr = 16384;  wi = 0;      end
      endcase
      pr = (br * wr - bi * wi) >>> 14;
      pi = (br * wi + bi * wr) >>> 14;
      return {24'(ar + pr), 24'(ai + pi), 24'(ar - pr), 24'(ai - pi)};
   endfunction

   // ---------------- RAM + butterfly model ----------------
   logic [CW-1:0] ram [N];
   logic [CW-1:0] init_ram [N];
   logic          load_req = 1'b0;
   logic [CW-1:0] rd_a, rd_b;
   logic [1:0]    rd_tw;
   logic [95:0]   res;
   logic          pipe_v [8];
   logic [CW-1:0] pipe_a [8];
   logic [CW-1:0] pipe_b [8];
   int            latency = 3;
   logic          force_v = 1'b0;

   always_comb res = bfly(rd_a, rd_b, int'(rd_tw));

   always @(posedge clk) begin
      if (load_req) for (int i = 0; i < N; i++) ram[i] <= init_ram[i];
      if (o_rd_en) begin
         rd_a  <= ram[o_rd_addr_a];
         rd_b  <= ram[o_rd_addr_b];
         rd_tw <= o_tw_addr;
      end
      if (o_wr_en) begin
         ram[o_wr_addr_a] <= o_wr_data_a;
         ram[o_wr_addr_b] <= o_wr_data_b;
      end
      if (!reset) begin
         for (int i = 0; i < 8; i++) pipe_v[i] <= 1'b0;
      end else begin
         pipe_v[0] <= o_bfly_start;
         pipe_a[0] <= res[95:48];
         pipe_b[0] <= res[47:0];
         for (int i = 1; i < 8; i++) begin
            pipe_v[i] <= pipe_v[i-1];
            pipe_a[i] <= pipe_a[i-1];
            pipe_b[i] <= pipe_b[i-1];
         end
      end
   end

   always_comb begin
      i_bfly_valid  = force_v | o_bfly_start;
      i_bfly_data_a = res[95:48];
      i_bfly_data_b = res[47:0];
      if (latency != 0) begin
         i_bfly_valid  = force_v | pipe_v[latency-1];
         i_bfly_data_a = pipe_a[latency-1];
         i_bfly_data_b = pipe_b[latency-1];
      end
   end

   // ---------------- event monitor ----------------
   typedef struct { int a; int b; int tw; int cyc; } ev_t;
   ev_t rd_log[$];
   ev_t wr_log[$];
   int  cyc_cnt = 0;
   int  done_cnt = 0;

   always @(negedge clk) begin
      cyc_cnt <= cyc_cnt + 1;
      if (o_rd_en) rd_log.push_back(ev_t'{int'(o_rd_addr_a), int'(o_rd_addr_b), int'(o_tw_addr), cyc_cnt});
      if (o_wr_en) wr_log.push_back(ev_t'{int'(o_wr_addr_a), int'(o_wr_addr_b), 0, cyc_cnt});
      if (o_done) done_cnt <= done_cnt + 1;
   end

   // ---------------- checking ----------------
   typedef struct { int a; int b; int tw; } rd_vec_t;
   rd_vec_t exp_rd [12];
   logic [CW-1:0] ref_ram [N];
   logic [CW-1:0] snap [N];
   int n_pass = 0, n_total = 0;
   int rd0, wr0, dn0;

   task automatic check(input string name, input longint act, input longint exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   task automatic check_le(input string name, input longint act, input longint lim);
      n_total++;
      if (act <= lim) n_pass++;
      else $display("FAIL %s: got %0d expected at most %0d", name, act, lim);
   endtask

   task automatic check_near(input string name, input longint act, input longint exp);
      n_total++;
      if (act >= exp - 2 && act <= exp + 2) n_pass++;
      else $display("FAIL %s: got %0d expected %0d +-2", name, act, exp);
   endtask

   task automatic do_reset();
      reset = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
   endtask

   task automatic load_ram(input bit impulse);
      for (int i = 0; i < N; i++) init_ram[i] = '0;
      if (impulse) init_ram[0] = {24'sd2000, 24'sd0};
      else begin
         init_ram[1] = {24'sd1000, 24'sd0};
         init_ram[2] = {24'sd0, 24'sd500};
         init_ram[3] = {-24'sd300, 24'sd200};
         init_ram[6] = {24'sd123, -24'sd77};
      end
      load_req = 1'b1;
      @(negedge clk);
      load_req = 1'b0;
   endtask

   task automatic compute_ref();
      logic [95:0] r;
      for (int i = 0; i < N; i++) ref_ram[i] = init_ram[i];
      for (int i = 0; i < 12; i++) begin
         r = bfly(ref_ram[exp_rd[i].a], ref_ram[exp_rd[i].b], exp_rd[i].tw);
         ref_ram[exp_rd[i].a] = r[95:48];
         ref_ram[exp_rd[i].b] = r[47:0];
      end
   endtask

   task automatic run_fft(input int lat, input bit mid_start);
      int cycles;
      latency = lat;
      rd0 = rd_log.size(); wr0 = wr_log.size(); dn0 = done_cnt;
      i_start = 1'b1;
      @(negedge clk);
      i_start = 1'b0;
      cycles = 1;
      check("busy_after_start", o_busy, 1);
      while (!o_done && cycles < 300) begin
         @(negedge clk);
         cycles++;
         i_start = mid_start && (cycles == 12);
      end
      i_start = 1'b0;
      check("done_seen", o_done, 1);
      check_le("cycles_to_done", cycles, LOG2N * (N/2 + lat + 3) + 1);
      @(negedge clk);
      check("busy_fall", o_busy, 0);
      repeat (3) @(negedge clk);
      check("done_once", done_cnt - dn0, 1);
      check("wr_count", wr_log.size() - wr0, 12);
      check("rd_count", rd_log.size() - rd0, 12);
   endtask

   task automatic check_sequence();
      for (int i = 0; i < 12; i++) begin
         if (rd0 + i < rd_log.size()) begin
            check("rd_addr_a", rd_log[rd0+i].a, exp_rd[i].a);
            check("rd_addr_b", rd_log[rd0+i].b, exp_rd[i].b);
            check("tw_addr",   rd_log[rd0+i].tw, exp_rd[i].tw);
         end
         if (wr0 + i < wr_log.size()) begin
            check("wr_addr_a", wr_log[wr0+i].a, exp_rd[i].a);
            check("wr_addr_b", wr_log[wr0+i].b, exp_rd[i].b);
         end
      end
      for (int s = 0; s < LOG2N - 1; s++) begin
         if (rd0 + 4*(s+1) < rd_log.size() && wr0 + 4*s + 3 < wr_log.size())
            check("raw_hazard", rd_log[rd0+4*(s+1)].cyc > wr_log[wr0+4*s+3].cyc, 1);
      end
   endtask

   task automatic check_impulse_ram();
      for (int i = 0; i < N; i++) begin
         check_near("bin_re", longint'($signed(ram[i][47:24])), 2000);
         check_near("bin_im", longint'($signed(ram[i][23:0])), 0);
      end
   endtask

   initial begin
      exp_rd[0]  = '{0, 1, 0}; exp_rd[1]  = '{2, 3, 0}; exp_rd[2]  = '{4, 5, 0}; exp_rd[3]  = '{6, 7, 0};
      exp_rd[4]  = '{0, 2, 0}; exp_rd[5]  = '{1, 3, 2}; exp_rd[6]  = '{4, 6, 0}; exp_rd[7]  = '{5, 7, 2};
      exp_rd[8]  = '{0, 4, 0}; exp_rd[9]  = '{1, 5, 1}; exp_rd[10] = '{2, 6, 2}; exp_rd[11] = '{3, 7, 3};

      // Reset state
      do_reset();
      check("rst_busy", o_busy, 0);
      check("rst_done", o_done, 0);
      check("rst_err", o_err, 0);
      check("rst_rd_en", o_rd_en, 0);
      check("rst_bfly_start", o_bfly_start, 0);
      check("rst_wr_en", o_wr_en, 0);

      // Impulse transform, L=3
      load_ram(1'b1);
      run_fft(3, 1'b0);
      check_sequence();
      check_impulse_ram();
      check("err_after_run", o_err, 0);

      // Start pulse mid-run must be ignored
      load_ram(1'b1);
      run_fft(3, 1'b1);
      check_sequence();
      check_impulse_ram();

      // Reset during stage 1, then a clean transform
      load_ram(1'b1);
      latency = 3;
      rd0 = rd_log.size();
      i_start = 1'b1;
      @(negedge clk);
      i_start = 1'b0;
      for (int w = 0; w < 100 && (rd_log.size() - rd0) < 5; w++) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      check("midrst_busy", o_busy, 0);
      check("midrst_rd_en", o_rd_en, 0);
      check("midrst_wr_en", o_wr_en, 0);
      check("midrst_bfly_start", o_bfly_start, 0);
      check("midrst_rd_addr", {o_rd_addr_a, o_rd_addr_b, o_tw_addr}, 0);
      rd0 = rd_log.size(); wr0 = wr_log.size();
      repeat (8) @(negedge clk);
      check("midrst_no_rd", rd_log.size() - rd0, 0);
      check("midrst_no_wr", wr_log.size() - wr0, 0);
      load_ram(1'b1);
      run_fft(3, 1'b0);
      check_sequence();
      check_impulse_ram();
      check("err_after_midrst", o_err, 0);

      // Latency 0 and 6 on a non-trivial pattern must match the reference
      load_ram(1'b0);
      compute_ref();
      run_fft(0, 1'b0);
      for (int i = 0; i < N; i++) begin
         snap[i] = ram[i];
         check("l0_vs_ref", ram[i], ref_ram[i]);
      end
      load_ram(1'b0);
      run_fft(6, 1'b0);
      check_sequence();
      for (int i = 0; i < N; i++) check("l6_vs_l0", ram[i], snap[i]);
      check("err_after_l6", o_err, 0);
      latency = 3;

      // Valid while idle: sticky error, no write
      wr0 = wr_log.size();
      force_v = 1'b1;
      @(negedge clk);
      force_v = 1'b0;
      check("idle_valid_err", o_err, 1);
      check("idle_valid_no_wr", o_wr_en, 0);
      repeat (4) @(negedge clk);
      check("err_sticky", o_err, 1);
      check("idle_valid_wr_count", wr_log.size() - wr0, 0);
      do_reset();
      check("err_cleared_by_reset", o_err, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/fft_stage_sequencer.md
Name: fft_stage_sequencer

Overview:
Control block that drives the fft_butterfly operand side (i_start/data/twiddle) and consumes its result side (o_valid/outputs). It runs an in-place radix-2 DIT FFT over an external dual-port sample RAM holding bit-reversed input. It generates read addresses and twiddle ROM addresses, pulses the butterfly start, tracks in-flight butterflies, and writes results back to the same addresses. It sits between the capture buffer and the magnitude stage.

Parameters:
LOG2N, 10, log2 of transform length N (bench uses 3)
DATA_WIDTH, 24, width of each real/imag component
FIFO_DEPTH, 8, pending write-back address-pair slots (power of 2, must be ≥ butterfly latency + 2)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset
i_start  in  1  pulse: begin a transform (ignored while busy)
o_busy  out  1  high from the cycle after an accepted i_start until o_done
o_done  out  1  one-cycle pulse after the final write-back
o_err  out  1  sticky protocol error, cleared only by reset
o_rd_en  out  1  RAM read strobe; data valid on the next cycle (synchronous RAM)
o_rd_addr_a  out  LOG2N  RAM read address, operand A
o_rd_addr_b  out  LOG2N  RAM read address, operand B
o_tw_addr  out  LOG2N-1  twiddle ROM address, same cycle as o_rd_en
o_bfly_start  out  1  to butterfly i_start, aligned with RAM/ROM read data
i_bfly_valid  in  1  from butterfly o_valid
i_bfly_data_a  in  2*DATA_WIDTH  butterfly output A {re,im}
i_bfly_data_b  in  2*DATA_WIDTH  butterfly output B {re,im}
o_wr_en  out  1  RAM write strobe, both ports
o_wr_addr_a  out  LOG2N  RAM write address, port A
o_wr_addr_b  out  LOG2N  RAM write address, port B
o_wr_data_a  out  2*DATA_WIDTH  registered i_bfly_data_a
o_wr_data_b  out  2*DATA_WIDTH  registered i_bfly_data_b

Behaviour:
- Reset (reset==0 at a clk edge): every output is 0, state is IDLE, counters are 0, FIFO is flushed. This applies mid-transform too, with no further reads or writes.
- FSM: IDLE -> RUN on i_start. RUN -> DRAIN after the issue with k==N/2-1. DRAIN -> RUN (stage+1) when outstanding==0 and stage<LOG2N-1. DRAIN -> DONE when outstanding==0 at the last stage. DONE -> IDLE after one cycle, with o_done=1 in DONE.
- RUN issues one butterfly per cycle, k=0..N/2-1. Stage s: half=1<<s, pos=k&(half-1), grp=k>>s.
  - addr_a = grp*2*half + pos
  - addr_b = addr_a + half
  - tw = pos << (LOG2N-1-s)
- Issue at cycle t: o_rd_en=1 with addr/tw. At t+1: o_bfly_start=1. RAM/ROM data is wired straight to the butterfly.
- At issue: push {addr_a, addr_b} into the FIFO and increment outstanding.
- On i_bfly_valid at cycle v: pop the FIFO and decrement outstanding. At v+1: o_wr_en=1 with popped addresses and registered data.
- Issue and valid in the same cycle: outstanding is unchanged; FIFO push and pop both occur.
- DRAIN enforces the inter-stage RAW hazard. No stage s+1 read occurs before the last stage s write has been presented (o_wr_en cycle completed).
- o_err is set by either of:
  - i_bfly_valid with the FIFO empty (including while IDLE); the pop is suppressed
  - a push with the FIFO full; the issue still proceeds
- i_start while busy: ignored, no error.
- Total cycles per transform are LOG2N*(N/2 + L + 3) + 1 for butterfly latency L. The bench checks this as an upper bound.

Decomposition:
- Shared package fft_pkg: complex width macro (2*DATA_WIDTH), FSM state encodings (IDLE/RUN/DRAIN/DONE), LOG2N default.
- One sub-module: fft_addr_fifo, a synchronous FIFO of {addr_a, addr_b} with full/empty and the same active-low reset.

Test Plan:
- LOG2N=3, model butterfly with L=3: read sequence -> stage0 (0,1)(2,3)(4,5)(6,7) tw 0,0,0,0; stage1 (0,2)(1,3)(4,6)(5,7) tw 0,2,0,2; stage2 (0,4)(1,5)(2,6)(3,7) tw 0,1,2,3.
- RAM x[0]={2000,0}, others 0, ideal-model butterfly -> final RAM all eight bins {2000,0} ±2 LSB; exactly 12 o_wr_en pulses; o_done exactly once; o_busy falls the cycle after.
- Hazard monitor across the full run -> no o_rd_en in stage s+1 before the final stage s o_wr_en; o_wr_addr pairs equal issued read pairs in order.
- reset=0 for one cycle during stage 1 -> next cycle all outputs 0, o_busy=0; a following i_start completes a correct transform.
- i_bfly_valid pulsed while IDLE -> o_err=1 and no o_wr_en; stays 1 until reset; i_start mid-run -> ignored, sequence unchanged.
- Model butterfly L=0 vs L=6 (FIFO_DEPTH=8) -> identical RAM contents, o_err stays 0.
